host_to_breakout_tx: RTL and testbench

- Host-side transmitter for the host-to-breakout serial link, running on the 120 MHz host clock.
- Generates the 10 MHz frame clock (o_clk_s) and the serial data line (o_d0_s).
- Every frame carries 12 bits: LED and port state, plus one bit of a multi-frame "slow word" that holds a 48-bit value and a reset flag.
- The breakout-side receiver decodes this stream into o_slow_value/o_slow_valid, o_reset and o_port.

---
 rtl/htb_pkg.sv | 40 ++++
 rtl/htb_frame_shifter.sv | 54 +++++
 rtl/host_to_breakout_tx.sv | 169 ++++++++++++++++
 tb/tb_host_to_breakout_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/htb_pkg.sv
// Shared constants, types and helpers for the host-to-breakout serial transmitter.
// Build option: define HTB_TX_SLOW_CRC_EN to append an 8-bit CRC to every slow word.
// With the option, a slow word is 57 sub-frames long. Without it, a slow word is 49 sub-frames long.
package htb_pkg;

  localparam int unsigned PORT_W_DEF = 8;
  localparam int unsigned LED_W_DEF  = 2;
  localparam int unsigned SLOW_W_DEF = 48;

  localparam int unsigned FRAME_BITS = 2 + LED_W_DEF + PORT_W_DEF;
  localparam int unsigned CLK_HIGH   = FRAME_BITS / 2;
  localparam int unsigned SYNC_BIT   = 11;
  localparam int unsigned SLOW_BIT   = 10;
  localparam int unsigned LED_LSB    = 8;
  localparam int unsigned PORT_LSB   = 0;

`ifdef HTB_TX_SLOW_CRC_EN
  localparam int unsigned CRC_W = 8;
`else
  localparam int unsigned CRC_W = 0;
`endif

  // Sub-frame 0 carries sync and the reset flag. The value bits follow, then the optional CRC bits.
  localparam int unsigned SLOW_SUBFRAMES = 1 + SLOW_W_DEF + CRC_W;

  localparam logic [7:0] CRC_POLY = 8'h07;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_WORD = 1'b1
  } tx_state_e;

  // Advances a serial CRC-8 by one bit. The CRC is not reflected.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/htb_frame_shifter.sv
// Serializer for one frame. It also generates the frame clock.
// The parallel frame word is loaded on the last cycle of a frame, and it is shifted out MSB first.
// Ports:
//   i_clk, i_reset  host clock and asynchronous active-high reset
//   i_k             frame counter for the current cycle
//   i_frame         frame word. It is sampled when i_k is at the last count.
//   o_clk_s         frame clock. It is high for the first half of every frame.
//   o_d0_s          serial data
module htb_frame_shifter #(
  parameter int unsigned FR_BITS = htb_pkg::FRAME_BITS,
  parameter int unsigned K_W     = $clog2(FR_BITS)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [K_W-1:0]     i_k,
  input  logic [FR_BITS-1:0] i_frame,
  output logic               o_clk_s,
  output logic               o_d0_s
);

  logic               load;
  logic [K_W-1:0]     k_nxt;
  logic [FR_BITS-1:0] sh_q, sh_d;
  logic               d0_q, d0_d;
  logic               clk_q, clk_d;

  // The outputs are registered. Because of this, they are computed from the k value of the next cycle.
  always_comb begin
    load  = (i_k == K_W'(FR_BITS - 1));
    k_nxt = load ? '0 : i_k + K_W'(1);
    clk_d = (k_nxt < K_W'(FR_BITS / 2));
    if (load) begin
      {d0_d, sh_d} = {i_frame, 1'b0};
    end else begin
      {d0_d, sh_d} = {sh_q, 1'b0};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sh_q  <= '0;
      d0_q  <= 1'b0;
      clk_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      d0_q  <= d0_d;
      clk_q <= clk_d;
    end
  end

  assign o_clk_s = clk_q;
  assign o_d0_s  = d0_q;

endmodule

// File: rtl/host_to_breakout_tx.sv
// Host-side transmitter for the host-to-breakout link. Each frame has FRAME_BITS bits.
// A frame holds the sync bit, one slow-word bit, the LED field and the port field.
// Build option: HTB_TX_SLOW_CRC_EN appends a CRC-8 to every slow word.
// The CRC polynomial is 0x07. The CRC covers the value bits in transmit order.
// Ports:
//   i_clk, i_reset               host clock and asynchronous active-high reset
//   i_port, i_led                field values. They are sampled on the last cycle of each frame.
//   i_slow_value, i_slow_valid   slow-word payload and its valid flag
//   o_slow_ready                 slow-word ready
//   i_reset_req                  pulse that requests a remote reset
//   o_clk_s, o_d0_s              frame clock and serial data
module host_to_breakout_tx
  import htb_pkg::*;
#(
  parameter int unsigned PORT_W = 8,
  parameter int unsigned LED_W  = 2,
  parameter int unsigned SLOW_W = 48
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [PORT_W-1:0] i_port,
  input  logic [LED_W-1:0]  i_led,
  input  logic [SLOW_W-1:0] i_slow_value,
  input  logic              i_slow_valid,
  output logic              o_slow_ready,
  input  logic              i_reset_req,
  output logic              o_clk_s,
  output logic              o_d0_s
);

  localparam int unsigned FB    = 2 + LED_W + PORT_W;
  localparam int unsigned K_W   = $clog2(FB);
  localparam int unsigned NSUB  = 1 + SLOW_W + CRC_W;
  localparam int unsigned SUB_W = $clog2(NSUB);

  logic [K_W-1:0]    k_q, k_d;
  tx_state_e         state_q, state_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic              pend_q, pend_d;
  logic [SLOW_W-1:0] pend_val_q, pend_val_d;
  logic [SLOW_W-1:0] val_sh_q, val_sh_d;
  logic              flag_q, flag_d;
  logic              ready_q, ready_d;
`ifdef HTB_TX_SLOW_CRC_EN
  logic [7:0]        crc_q, crc_d;
`endif

  logic          accept;
  logic          flag_eff;
  logic          frame_end;
  logic          last_sub;
  logic          sync_bit;
  logic          slow_bit;
  logic [FB-1:0] frame;

  // Slow-word sequencing. The next frame word is decided on the last cycle of each frame.
  always_comb begin
    k_d        = k_q;
    state_d    = state_q;
    sub_d      = sub_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    val_sh_d   = val_sh_q;
    ready_d    = ready_q;
    sync_bit   = 1'b0;
    slow_bit   = 1'b0;
`ifdef HTB_TX_SLOW_CRC_EN
    crc_d      = crc_q;
`endif

    accept    = i_slow_valid && ready_q;
    // A request that arrives on the cycle that builds sub-frame 0 is carried by that word.
    flag_eff  = flag_q | i_reset_req;
    flag_d    = flag_eff;
    frame_end = (k_q == K_W'(FB - 1));
    last_sub  = (state_q == TX_WORD) && (sub_q == SUB_W'(NSUB - 1));
    k_d       = frame_end ? '0 : k_q + K_W'(1);

    if (accept) begin
      pend_val_d = i_slow_value;
      pend_d     = 1'b1;
      ready_d    = 1'b0;
    end

    // Ready goes high again on the last cycle of the final sub-frame.
    // This lets the next word start immediately after the current word.
    if ((k_q == K_W'(FB - 2)) && last_sub) begin
      ready_d = 1'b1;
    end

    if (frame_end) begin
      if ((state_q == TX_WORD) && !last_sub) begin
        sub_d = sub_q + SUB_W'(1);
        if (sub_q < SUB_W'(SLOW_W)) begin
          slow_bit = val_sh_q[SLOW_W-1];
          val_sh_d = {val_sh_q[SLOW_W-2:0], 1'b0};
`ifdef HTB_TX_SLOW_CRC_EN
          crc_d    = crc8_step(crc_q, val_sh_q[SLOW_W-1]);
        end else begin
          slow_bit = crc_q[7];
          crc_d    = {crc_q[6:0], 1'b0};
`endif
        end
      end else if (pend_q || accept || flag_eff) begin
        // A word that carries only the reset flag sends the last latched value again.
        state_d  = TX_WORD;
        sub_d    = '0;
        sync_bit = 1'b1;
        slow_bit = flag_eff;
        flag_d   = 1'b0;
        pend_d   = 1'b0;
        val_sh_d = accept ? i_slow_value : pend_val_q;
        if (!accept) begin
          ready_d = 1'b0;
        end
`ifdef HTB_TX_SLOW_CRC_EN
        crc_d    = 8'h00;
`endif
      end else begin
        state_d = TX_IDLE;
      end
    end

    frame = {sync_bit, slow_bit, i_led, i_port};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      k_q        <= K_W'(FB - 1);
      state_q    <= TX_IDLE;
      sub_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      val_sh_q   <= '0;
      flag_q     <= 1'b0;
      ready_q    <= 1'b1;
`ifdef HTB_TX_SLOW_CRC_EN
      crc_q      <= 8'h00;
`endif
    end else begin
      k_q        <= k_d;
      state_q    <= state_d;
      sub_q      <= sub_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      val_sh_q   <= val_sh_d;
      flag_q     <= flag_d;
      ready_q    <= ready_d;
`ifdef HTB_TX_SLOW_CRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

  htb_frame_shifter #(
    .FR_BITS (FB),
    .K_W     (K_W)
  ) u_shifter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_k     (k_q),
    .i_frame (frame),
    .o_clk_s (o_clk_s),
    .o_d0_s  (o_d0_s)
  );

  assign o_slow_ready = ready_q;

endmodule

// File: tb/tb_host_to_breakout_tx.sv
// Directed bench for host_to_breakout_tx. Frames are captured serially and checked against hand-computed words.
module tb_host_to_breakout_tx;

`ifdef HTB_TX_SLOW_CRC_EN
  localparam int NSUB = 57;
`else
  localparam int NSUB = 49;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  port;
  logic [1:0]  led;
  logic [47:0] val;
  logic        valid;
  logic        ready;
  logic        req;
  logic        clk_s;
  logic        d0;

  int n_chk  = 0;
  int n_pass = 0;
  int kb;

  logic [11:0] fbuf, cbuf;
  logic [11:0] fq[$];
  logic [11:0] cq[$];
  logic [7:0]  crcg;
  logic [11:0] f, c;

  host_to_breakout_tx dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_port       (port),
    .i_led        (led),
    .i_slow_value (val),
    .i_slow_valid (valid),
    .o_slow_ready (ready),
    .i_reset_req  (req),
    .o_clk_s      (clk_s),
    .o_d0_s       (d0)
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Expected frame position. The first clock edge after reset is released gives position 0.
  always @(posedge clk or posedge rst) begin
    if (rst) kb <= 11;
    else     kb <= (kb == 11) ? 0 : kb + 1;
  end

  // Captures one frame per 12 cycles. Sampling is done at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      fbuf[11-kb] = d0;
      cbuf[11-kb] = clk_s;
      if (kb == 11) begin
        fq.push_back(fbuf);
        cq.push_back(cbuf);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

`ifdef HTB_TX_SLOW_CRC_EN
  function automatic logic [7:0] crc8_model(input logic [47:0] v);
    logic [7:0] cr;
    cr = 8'h00;
    for (int i = 47; i >= 0; i--) begin
      if (cr[7] ^ v[i]) cr = {cr[6:0], 1'b0} ^ 8'h07;
      else              cr = {cr[6:0], 1'b0};
    end
    return cr;
  endfunction
`endif

  task automatic wait_k(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (kb != k && n < 30);
    if (kb != k) check_eq("wait_k", 64'(kb), 64'(k));
  endtask

  task automatic word_frames(input int n);
    for (int i = 0; i < n; i++) wait_k(11);
  endtask

  task automatic flush();
    fq.delete();
    cq.delete();
  endtask

  task automatic pop_frame(output logic [11:0] fo, output logic [11:0] co);
    if (fq.size() == 0) begin
      check_eq("frame_q_level", 64'(fq.size()), 64'd1);
      fo = '0;
      co = '0;
    end else begin
      fo = fq.pop_front();
      co = cq.pop_front();
    end
  endtask

  task automatic check_word(input string tag, input logic flag_exp, input logic [47:0] v_exp,
                            input logic [9:0] rest_exp, output logic [7:0] crc_got);
    logic [11:0] wf, wc;
    logic [47:0] bits;
    logic [7:0]  crcb;
    logic        sync_or, rest_bad, clk_bad;
    bits = '0; crcb = '0; sync_or = 1'b0; rest_bad = 1'b0; clk_bad = 1'b0;
    pop_frame(wf, wc);
    check_eq({tag, "_sub0"}, 64'(wf), 64'({1'b1, flag_exp, rest_exp}));
    for (int i = 1; i < NSUB; i++) begin
      pop_frame(wf, wc);
      sync_or  |= wf[11];
      rest_bad |= (wf[9:0] != rest_exp);
      clk_bad  |= (wc != 12'hFC0);
      if (i <= 48) bits = {bits[46:0], wf[10]};
      else         crcb = {crcb[6:0], wf[10]};
    end
    check_eq({tag, "_value"}, 64'(bits), 64'(v_exp));
    check_eq({tag, "_sync_later"}, 64'(sync_or), 64'd0);
    check_eq({tag, "_fields"}, 64'(rest_bad), 64'd0);
    check_eq({tag, "_clk_s"}, 64'(clk_bad), 64'd0);
`ifdef HTB_TX_SLOW_CRC_EN
    check_eq({tag, "_crc"}, 64'(crcb), 64'(crc8_model(v_exp)));
`endif
    crc_got = crcb;
  endtask

  initial begin
    rst = 1'b1; led = 2'b01; port = 8'hCE; val = '0; valid = 1'b0; req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_clk_s", 64'(clk_s), 64'd0);
    check_eq("rst_d0", 64'(d0), 64'd0);
    check_eq("rst_ready", 64'(ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("first_k0_clk_s", 64'(clk_s), 64'd1);
    check_eq("first_k0_d0", 64'(d0), 64'd0);

    // Idle frames with LED=01 and port=CE.
    flush();
    wait_k(0); wait_k(0);
    for (int i = 0; i < 2; i++) begin
      pop_frame(f, c);
      check_eq("idle_frame", 64'(f), 64'h1CE);
      check_eq("idle_clk_s", 64'(c), 64'hFC0);
    end

    // A single slow word.
    wait_k(3);
    check_eq("ready_idle", 64'(ready), 64'd1);
    val = 48'h123456789ABC; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check_eq("ready_after_accept", 64'(ready), 64'd0);
    wait_k(0);
    flush();
    check_eq("ready_in_flight", 64'(ready), 64'd0);
    word_frames(NSUB - 1);
    wait_k(10);
    check_eq("ready_last_k10", 64'(ready), 64'd0);
    wait_k(11);
    check_eq("ready_last_k11", 64'(ready), 64'd1);
    wait_k(0);
    check_word("word1", 1'b0, 48'h123456789ABC, 10'h1CE, crcg);

    // A reset request while idle produces a reset-only word that repeats the last value.
    wait_k(3);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check_eq("ready_before_rstword", 64'(ready), 64'd1);
    wait_k(0);
    flush();
    check_eq("ready_rstword", 64'(ready), 64'd0);
    word_frames(NSUB);
    wait_k(0);
    check_word("rstword", 1'b1, 48'h123456789ABC, 10'h1CE, crcg);

    // Two words back to back while valid stays high.
    wait_k(3);
    val = 48'hA5A50000FFFF; valid = 1'b1;
    @(negedge clk);
    val = 48'h0F0F12345678;
    check_eq("ready_word_a", 64'(ready), 64'd0);
    wait_k(0);
    flush();
    word_frames(NSUB);
    check_eq("ready_a_end", 64'(ready), 64'd1);
    @(negedge clk);
    valid = 1'b0;
    check_eq("ready_word_b", 64'(ready), 64'd0);
    word_frames(NSUB);
    wait_k(0);
    check_word("word_a", 1'b0, 48'hA5A50000FFFF, 10'h1CE, crcg);
    check_word("word_b", 1'b0, 48'h0F0F12345678, 10'h1CE, crcg);

    // A port change in the middle of a frame takes effect in the next frame.
    wait_k(0);
    flush();
    wait_k(4);
    port = 8'h35;
    wait_k(0); wait_k(0);
    pop_frame(f, c);
    check_eq("port_cur_frame", 64'(f), 64'h1CE);
    pop_frame(f, c);
    check_eq("port_next_frame", 64'(f), 64'h135);

`ifdef HTB_TX_SLOW_CRC_EN
    wait_k(3);
    val = 48'h000000000001; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_k(0);
    flush();
    word_frames(NSUB);
    wait_k(0);
    check_word("crc_word", 1'b0, 48'h000000000001, 10'h135, crcg);
    check_eq("crc_of_one", 64'(crcg), 64'h07);
`endif

    // Asynchronous reset in the middle of a word.
    wait_k(3);
    val = 48'hFFFF0000AAAA; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_k(0);
    word_frames(20);
    wait_k(5);
    check_eq("pre_reset_clk_s", 64'(clk_s), 64'd1);
    check_eq("pre_reset_ready", 64'(ready), 64'd0);
    rst = 1'b1;
    #1;
    check_eq("midrst_clk_s", 64'(clk_s), 64'd0);
    check_eq("midrst_d0", 64'(d0), 64'd0);
    check_eq("midrst_ready", 64'(ready), 64'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_k0_clk_s", 64'(clk_s), 64'd1);
    check_eq("post_rst_ready", 64'(ready), 64'd1);
    flush();
    wait_k(0); wait_k(0);
    for (int i = 0; i < 2; i++) begin
      pop_frame(f, c);
      check_eq("post_rst_idle", 64'(f), 64'h135);
    end

    // After reset, a reset-only word carries a value of zero.
    wait_k(3);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_k(0);
    flush();
    word_frames(NSUB);
    wait_k(0);
    check_word("rst_zero", 1'b1, 48'h0, 10'h135, crcg);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
